// File: rtl/pirisc_pkg.sv
// Shared opcode constants, FSM state type and data-path select encodings
// for the PiRISC control path.
package pirisc_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JALR   = 2'b10;
    localparam logic [1:0] PC_JAL    = 2'b11;

    localparam logic [1:0] WB_ALU    = 2'b00;
    localparam logic [1:0] WB_RAM    = 2'b01;
    localparam logic [1:0] WB_LINK   = 2'b10;
    localparam logic [1:0] WB_IMM    = 2'b11;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } stateT;

    typedef enum logic [3:0] {
        CLS_ALU,
        CLS_LUI,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_SYSTEM,
        CLS_ILLEGAL
    } instrClassT;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct3 classifier: instruction class, ALU operand
// source, one-hot memory access width and legality.
import pirisc_pkg::*;

module ctrl_decode (
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    output instrClassT  instrClass,
    output logic        aluSrc,
    output logic [2:0]  widthOneHot,
    output logic        legal
);

    logic unusedFunct3;
    assign unusedFunct3 = funct3[2];

    // widthOneHot is {word, half, byte}; only memory ops select a width
    always_comb begin
        instrClass  = CLS_ILLEGAL;
        aluSrc      = 1'b1;
        widthOneHot = 3'b000;
        legal       = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                instrClass = CLS_ALU;
                aluSrc     = 1'b0;
            end
            OP_IALU, OP_AUIPC: instrClass = CLS_ALU;
            OP_LUI:            instrClass = CLS_LUI;
            OP_LOAD, OP_STORE: begin
                if (opcode == OP_LOAD) begin
                    instrClass = CLS_LOAD;
                end else begin
                    instrClass = CLS_STORE;
                end
                case (funct3[1:0])
                    2'b00:   widthOneHot = 3'b001;
                    2'b01:   widthOneHot = 3'b010;
                    2'b10:   widthOneHot = 3'b100;
                    default: legal       = 1'b0;
                endcase
            end
            OP_BRANCH: begin
                instrClass = CLS_BRANCH;
                aluSrc     = 1'b0;
            end
            OP_JAL:    instrClass = CLS_JAL;
            OP_JALR:   instrClass = CLS_JALR;
            OP_SYSTEM: instrClass = CLS_SYSTEM;
            default:   legal      = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle PiRISC control FSM: sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives the data-path controls (Moore style).
import pirisc_pkg::*;

module control_fsm #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [DWIDTH-1:0] instr,
    output logic              pcEn,
    output logic [1:0]        pcSelect,
    output logic              regWrite,
    output logic              aluSrc,
    output logic              ramRdEn,
    output logic              ramWrEn,
    output logic              isByte,
    output logic              isHalf,
    output logic              isWord,
    output logic [1:0]        memToReg,
    output logic              halted,
    output logic              illegal,
    output logic [DWIDTH-1:0] retired
);

    stateT      state;
    stateT      nextState;
    logic [6:0] opcodeReg;
    logic [2:0] funct3Reg;
    logic [6:0] decOpcode;
    logic [2:0] decFunct3;
    instrClassT instrClass;
    logic       decAluSrc;
    logic [2:0] widthOneHot;
    logic       legal;

    logic unusedInstr;
    assign unusedInstr = ^{instr[DWIDTH-1:15], instr[11:7]};

    // Classify the live instruction while in DECODE, the latched copy afterwards
    assign decOpcode = (state == DECODE) ? instr[6:0]   : opcodeReg;
    assign decFunct3 = (state == DECODE) ? instr[14:12] : funct3Reg;

    ctrl_decode decodeUnit (
        .opcode      (decOpcode),
        .funct3      (decFunct3),
        .instrClass  (instrClass),
        .aluSrc      (decAluSrc),
        .widthOneHot (widthOneHot),
        .legal       (legal)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= FETCH;
            opcodeReg <= '0;
            funct3Reg <= '0;
            illegal   <= 1'b0;
            retired   <= '0;
        end else begin
            state <= nextState;
            if (state == DECODE) begin
                opcodeReg <= instr[6:0];
                funct3Reg <= instr[14:12];
                if (!legal) begin
                    illegal <= 1'b1;
                end
            end
            if (pcEn) begin
                retired <= retired + DWIDTH'(1);
            end
        end
    end

    always_comb begin
        nextState = state;
        pcEn      = 1'b0;
        pcSelect  = PC_PLUS4;
        regWrite  = 1'b0;
        aluSrc    = 1'b0;
        ramRdEn   = 1'b0;
        ramWrEn   = 1'b0;
        isByte    = 1'b0;
        isHalf    = 1'b0;
        isWord    = 1'b0;
        memToReg  = WB_ALU;
        halted    = 1'b0;
        if (state == EXEC || state == MEM || state == WB) begin
            aluSrc = decAluSrc;
            isByte = widthOneHot[0];
            isHalf = widthOneHot[1];
            isWord = widthOneHot[2];
        end
        case (state)
            FETCH: begin
                if (run) begin
                    nextState = DECODE;
                end
            end
            DECODE: begin
                if (!legal || instrClass == CLS_SYSTEM) begin
                    nextState = HALT;
                end else begin
                    nextState = EXEC;
                end
            end
            EXEC: begin
                case (instrClass)
                    CLS_BRANCH: begin
                        pcEn      = 1'b1;
                        pcSelect  = PC_BRANCH;
                        nextState = FETCH;
                    end
                    CLS_LOAD, CLS_STORE: nextState = MEM;
                    default:             nextState = WB;
                endcase
            end
            MEM: begin
                if (instrClass == CLS_LOAD) begin
                    ramRdEn   = 1'b1;
                    nextState = WB;
                end else begin
                    ramWrEn   = 1'b1;
                    pcEn      = 1'b1;
                    pcSelect  = PC_PLUS4;
                    nextState = FETCH;
                end
            end
            WB: begin
                pcEn      = 1'b1;
                regWrite  = 1'b1;
                nextState = FETCH;
                case (instrClass)
                    CLS_LUI:  memToReg = WB_IMM;
                    CLS_LOAD: begin
                        ramRdEn  = 1'b1;
                        memToReg = WB_RAM;
                    end
                    CLS_JAL: begin
                        memToReg = WB_LINK;
                        pcSelect = PC_JAL;
                    end
                    CLS_JALR: begin
                        memToReg = WB_LINK;
                        pcSelect = PC_JALR;
                    end
                    default: begin
                        memToReg = WB_ALU;
                        pcSelect = PC_PLUS4;
                    end
                endcase
            end
            HALT:    halted    = 1'b1;
            default: nextState = FETCH;
        endcase
    end

endmodule

// File: tb/tb_control_fsm.sv
// Directed testbench for control_fsm: walks each instruction class cycle by
// cycle and compares the control bus against hand-computed values.
module tb_control_fsm;

    localparam int DWIDTH = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              run = 1'b0;
    logic [DWIDTH-1:0] instr = '0;
    logic              pcEn;
    logic [1:0]        pcSelect;
    logic              regWrite;
    logic              aluSrc;
    logic              ramRdEn;
    logic              ramWrEn;
    logic              isByte;
    logic              isHalf;
    logic              isWord;
    logic [1:0]        memToReg;
    logic              halted;
    logic              illegal;
    logic [DWIDTH-1:0] retired;
    logic [11:0]       ctrlBus;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    control_fsm #(.DWIDTH(DWIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .instr    (instr),
        .pcEn     (pcEn),
        .pcSelect (pcSelect),
        .regWrite (regWrite),
        .aluSrc   (aluSrc),
        .ramRdEn  (ramRdEn),
        .ramWrEn  (ramWrEn),
        .isByte   (isByte),
        .isHalf   (isHalf),
        .isWord   (isWord),
        .memToReg (memToReg),
        .halted   (halted),
        .illegal  (illegal),
        .retired  (retired)
    );

    assign ctrlBus = {pcEn, pcSelect, regWrite, aluSrc, ramRdEn, ramWrEn,
                      isByte, isHalf, isWord, memToReg};

    // Field order matches ctrlBus
    function automatic logic [11:0] ctl(input logic pe, input logic [1:0] ps,
                                        input logic rw, input logic as,
                                        input logic rd, input logic wr,
                                        input logic b, input logic h,
                                        input logic w, input logic [1:0] m2r);
        return {pe, ps, rw, as, rd, wr, b, h, w, m2r};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rstVal, input logic runVal,
                                 input logic [31:0] instrVal);
        reset = rstVal;
        run   = runVal;
        instr = instrVal;
    endtask

    // Called in a FETCH cycle; returns at the DECODE cycle with run dropped
    task automatic issue(input logic [31:0] code);
        applyStimulus(1'b1, 1'b1, code);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, code);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h0);
    endtask

    initial begin
        $display("[TB] starting control_fsm bench");
        doReset();
        checkOutput("resetCtrl", ctrlBus, 12'h000);
        checkOutput("resetHalted", halted, 1'b0);
        checkOutput("resetIllegal", illegal, 1'b0);
        checkOutput("resetRetired", retired, 32'd0);
        @(negedge clk);
        checkOutput("idleCtrl", ctrlBus, 12'h000);

        // ADD: R-type, WB at cycle 4
        issue(32'h002081B3);
        checkOutput("addDecode", ctrlBus, 12'h000);
        @(negedge clk);
        checkOutput("addExec", ctrlBus, 12'h000);
        @(negedge clk);
        checkOutput("addWb", ctrlBus, ctl(1, 2'b00, 1, 0, 0, 0, 0, 0, 0, 2'b00));
        @(negedge clk);
        checkOutput("addFetch", ctrlBus, 12'h000);
        checkOutput("addRetired", retired, 32'd1);

        // LW: word load through MEM and WB
        issue(32'h0080A283);
        @(negedge clk);
        checkOutput("lwExec", ctrlBus, ctl(0, 2'b00, 0, 1, 0, 0, 0, 0, 1, 2'b00));
        @(negedge clk);
        checkOutput("lwMem", ctrlBus, ctl(0, 2'b00, 0, 1, 1, 0, 0, 0, 1, 2'b00));
        @(negedge clk);
        checkOutput("lwWb", ctrlBus, ctl(1, 2'b00, 1, 1, 1, 0, 0, 0, 1, 2'b01));
        @(negedge clk);
        checkOutput("lwRetired", retired, 32'd2);

        // SB: byte store retires in MEM
        issue(32'h00208023);
        checkOutput("sbDecode", ctrlBus, 12'h000);
        @(negedge clk);
        checkOutput("sbExec", ctrlBus, ctl(0, 2'b00, 0, 1, 0, 0, 1, 0, 0, 2'b00));
        @(negedge clk);
        checkOutput("sbMem", ctrlBus, ctl(1, 2'b00, 0, 1, 0, 1, 1, 0, 0, 2'b00));
        @(negedge clk);
        checkOutput("sbFetch", ctrlBus, 12'h000);
        checkOutput("sbRetired", retired, 32'd3);

        // BEQ: retires in EXEC
        issue(32'h00208463);
        @(negedge clk);
        checkOutput("beqExec", ctrlBus, ctl(1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 2'b00));
        @(negedge clk);
        checkOutput("beqFetch", ctrlBus, 12'h000);
        checkOutput("beqRetired", retired, 32'd4);

        // JAL
        issue(32'h008000EF);
        @(negedge clk);
        checkOutput("jalExec", ctrlBus, ctl(0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 2'b00));
        @(negedge clk);
        checkOutput("jalWb", ctrlBus, ctl(1, 2'b11, 1, 1, 0, 0, 0, 0, 0, 2'b10));
        @(negedge clk);

        // LUI
        issue(32'h123450B7);
        @(negedge clk);
        @(negedge clk);
        checkOutput("luiWb", ctrlBus, ctl(1, 2'b00, 1, 1, 0, 0, 0, 0, 0, 2'b11));
        @(negedge clk);

        // JALR
        issue(32'h000080E7);
        @(negedge clk);
        @(negedge clk);
        checkOutput("jalrWb", ctrlBus, ctl(1, 2'b10, 1, 1, 0, 0, 0, 0, 0, 2'b10));
        @(negedge clk);
        checkOutput("jalrRetired", retired, 32'd7);

        // Reset asserted while LW sits in MEM
        issue(32'h0080A283);
        @(negedge clk);
        @(negedge clk);
        checkOutput("lwMemPreReset", ctrlBus, ctl(0, 2'b00, 0, 1, 1, 0, 0, 0, 1, 2'b00));
        applyStimulus(1'b0, 1'b0, 32'h0080A283);
        @(negedge clk);
        checkOutput("midResetCtrl", ctrlBus, 12'h000);
        checkOutput("midResetRetired", retired, 32'd0);
        checkOutput("midResetHalted", halted, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("postResetIdle", ctrlBus, 12'h000);
        issue(32'h002081B3);
        @(negedge clk);
        @(negedge clk);
        checkOutput("postResetAddWb", ctrlBus, ctl(1, 2'b00, 1, 0, 0, 0, 0, 0, 0, 2'b00));
        @(negedge clk);
        checkOutput("postResetRetired", retired, 32'd1);

        // ECALL: clean halt, stays halted even with run held high
        issue(32'h00000073);
        @(negedge clk);
        checkOutput("ecallHalted", halted, 1'b1);
        checkOutput("ecallIllegal", illegal, 1'b0);
        checkOutput("ecallCtrl", ctrlBus, 12'h000);
        applyStimulus(1'b1, 1'b1, 32'h002081B3);
        repeat (6) @(negedge clk);
        checkOutput("ecallStillHalted", halted, 1'b1);
        checkOutput("ecallStillCtrl", ctrlBus, 12'h000);
        checkOutput("ecallRetired", retired, 32'd1);

        // Load with funct3[1:0]=11 is an illegal width
        doReset();
        checkOutput("haltClearedByReset", halted, 1'b0);
        issue(32'h0080B283);
        @(negedge clk);
        checkOutput("badWidthHalted", halted, 1'b1);
        checkOutput("badWidthIllegal", illegal, 1'b1);
        checkOutput("badWidthCtrl", ctrlBus, 12'h000);

        // Unknown opcode 0x7F; illegal stays sticky
        doReset();
        checkOutput("illegalClearedByReset", illegal, 1'b0);
        issue(32'h0000007F);
        @(negedge clk);
        checkOutput("unknownHalted", halted, 1'b1);
        checkOutput("unknownIllegal", illegal, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h00000013);
        repeat (4) @(negedge clk);
        checkOutput("unknownSticky", illegal, 1'b1);
        checkOutput("unknownCtrl", ctrlBus, 12'h000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
